// File: rtl/alu_pipe.sv
// alu_pipe: registered RV32I register-register ALU with an optional
// iterative shift-add multiplier (MUL / MULHU). It uses valid/ready on both
// sides. Base ops complete in one cycle. A multiply takes XLEN iterations
// in S_MUL before its result is presented in S_OUT.
module alu_pipe #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [2:0]      funct3,
   input  logic            funct7,
   input  logic            mul_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   // The shift-amount width follows from XLEN and is never set on its own.
   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] LAST_CNT = SHW'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
   logic [XLEN-1:0]     mplier_q, mplier_d; // multiplier, shifted right each step
   logic [2*XLEN-1:0]   acc_q, acc_d;       // full-width product, so all-ones*all-ones fits
   logic [SHW-1:0]      cnt_q, cnt_d;
   logic                op_hi_q, op_hi_d;   // 1 = MULHU (upper half), 0 = MUL
   logic                rdy_en_q;           // holds in_ready low until one cycle after reset
   logic                accept;
   logic                launch;
   logic                is_mul;
   logic                start_mul;
   logic [2*XLEN-1:0]   partial;

   // Base RV32I register-register ALU evaluated at width XLEN.
   function automatic logic [XLEN-1:0] alu_base(
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b,
      input logic [2:0]      f3,
      input logic            f7
   );
      logic [XLEN-1:0] r;
      logic [SHW-1:0]  sh;
      sh = b[SHW-1:0];
      case (f3)
         3'b000: begin
            if (f7) begin
               r = a - b;
            end else begin
               r = a + b;
            end
         end
         3'b001: r = a << sh;
         3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
         3'b100: r = a ^ b;
         3'b101: begin
            // The signed shift stays in its own statement so that it
            // remains arithmetic.
            if (f7) begin
               r = $signed(a) >>> sh;
            end else begin
               r = a >> sh;
            end
         end
         3'b110: r = a | b;
         3'b111: r = a & b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Handshake and status outputs come straight from registered state.
   assign in_ready  = rdy_en_q && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q == S_MUL);
   assign result    = result_q;

   // Decode the incoming op. When the multiplier is absent, mul_en is ignored.
   always_comb begin
      accept    = in_valid && in_ready;
      is_mul    = (MUL_EN == 1'b1) && mul_en;
      start_mul = is_mul && ((funct3 == 3'b000) || (funct3 == 3'b011));
      partial   = mplier_q[0] ? mcand_q : '0;
   end

   // Next state, operand latching and the shift-add iteration.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      op_hi_d  = op_hi_q;
      launch   = 1'b0;

      case (state_q)
         S_IDLE: begin
            launch = accept;
         end
         S_OUT: begin
            if (out_ready) begin
               if (accept) begin
                  launch = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_OUT;
            end
         end
         S_MUL: begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_OUT;
               if (op_hi_q) begin
                  result_d = acc_d[2*XLEN-1:XLEN];
               end else begin
                  result_d = acc_d[XLEN-1:0];
               end
            end else begin
               state_d = S_MUL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A newly accepted op replaces whatever is being delivered this cycle.
      if (launch) begin
         if (start_mul) begin
            state_d  = S_MUL;
            mcand_d  = {{XLEN{1'b0}}, operand_a};
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = '0;
            op_hi_d  = (funct3 == 3'b011);
         end else if (is_mul) begin
            state_d  = S_OUT;
            result_d = '0;
         end else begin
            state_d  = S_OUT;
            result_d = alu_base(operand_a, operand_b, funct3, funct7);
         end
      end else begin
         op_hi_d = op_hi_d;
      end
   end

   // State and datapath registers. Reset discards any multiply in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         op_hi_q  <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         op_hi_q  <= op_hi_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: XLEN=32 with multiply and
// XLEN=8 without multiply.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, funct7, mul_en, out_valid, out_ready, busy;
   logic [2:0]  funct3;
   logic [31:0] operand_a, operand_b, result;

   logic        v8, rdy8, f7_8, m8, ov8, ordy8, busy8;
   logic [2:0]  f3_8;
   logic [7:0]  a8, b8, res8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_pipe #(.XLEN(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .funct3(funct3),
      .funct7(funct7), .mul_en(mul_en), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   alu_pipe #(.XLEN(8), .MUL_EN(1'b0)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
      .operand_a(a8), .operand_b(b8), .funct3(f3_8),
      .funct7(f7_8), .mul_en(m8), .out_valid(ov8),
      .out_ready(ordy8), .result(res8), .busy(busy8)
   );

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7, input logic m);
      in_valid  = 1'b1;
      operand_a = a;
      operand_b = b;
      funct3    = f3;
      funct7    = f7;
      mul_en    = m;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", result); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (res8 !== 8'h0) begin fails++; $display("FAIL reset_result8: got %h want 00", res8); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_base_ops;
      logic [31:0] va[12], vb[12], ve[12];
      logic [2:0]  vf3[12];
      logic        vf7[12], vm[12];
      va  = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
              32'h1, 32'hF0F0F0F0, 32'h12340000, 32'hF0F0F0F0, 32'h5, 32'h1};
      vb  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h24, 32'h24,
              32'd31, 32'hFF00FF00, 32'h00005678, 32'h3C3C3C3C, 32'h6, 32'h80000000};
      vf3 = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b101, 3'b101,
              3'b001, 3'b100, 3'b110, 3'b111, 3'b100, 3'b011};
      vf7 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ve  = '{32'h00000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h08000000,
              32'h80000000, 32'h0FF00FF0, 32'h12345678, 32'h30303030, 32'h0, 32'h1};
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(va[i], vb[i], vf3[i], vf7[i], vm[i]);
         @(negedge clk);
         in_valid = 1'b0;
         tests++;
         if (out_valid !== 1'b1 || result !== ve[i]) begin
            fails++;
            $display("FAIL base_op[%0d]: got valid=%b result=%h want valid=1 result=%h", i, out_valid, result, ve[i]);
         end
      end
   endtask

   task automatic test_mul;
      logic [31:0] ma[5], mb[5], me[5];
      logic        mh[5];
      int          busy_cnt, bad;
      ma = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h00010001};
      mb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h4, 32'h00010001};
      mh = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      me = '{32'h00000001, 32'hFFFFFFFE, 32'h0, 32'h2, 32'h00020001};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(ma[i], mb[i], mh[i] ? 3'b011 : 3'b000, 1'b0, 1'b1);
         busy_cnt = 0;
         bad = 0;
         for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         end
         @(negedge clk);
         tests++; if (busy_cnt != 32) begin fails++; $display("FAIL mul_busy_cycles[%0d]: got %0d want 32", i, busy_cnt); end
         tests++; if (bad != 0) begin fails++; $display("FAIL mul_stall[%0d]: got %0d bad cycles want 0", i, bad); end
         tests++;
         if (out_valid !== 1'b1 || busy !== 1'b0 || result !== me[i]) begin
            fails++;
            $display("FAIL mul_result[%0d]: got valid=%b busy=%b result=%h want valid=1 busy=0 result=%h",
                     i, out_valid, busy, result, me[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ba[4], bb[4];
      int          good;
      ba = '{32'd1, 32'd100, 32'h7FFFFFFF, 32'hFFFFFFFE};
      bb = '{32'd2, 32'd200, 32'd1, 32'd3};
      out_ready = 1'b1;
      good = 0;
      @(negedge clk);
      drive(ba[0], bb[0], 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1 && result === ba[i] + bb[i]) good++;
         if (i < 3) begin
            drive(ba[i+1], bb[i+1], 3'b000, 1'b0, 1'b0);
            #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
      end
      tests++; if (good != 4) begin fails++; $display("FAIL b2b_results: got %0d consecutive correct want 4", good); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got valid=%b want 0", out_valid); end
   endtask

   task automatic test_backpressure;
      int stable;
      out_ready = 1'b0;
      @(negedge clk);
      drive(32'd10, 32'd20, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || result !== 32'd30) begin fails++; $display("FAIL bp_first: got valid=%b result=%h want 1 0000001e", out_valid, result); end
      drive(32'd100, 32'd1, 3'b000, 1'b1, 1'b0);
      stable = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1 && result === 32'd30 && in_ready === 1'b0) stable++;
      end
      tests++; if (stable != 3) begin fails++; $display("FAIL bp_hold: got %0d stable cycles want 3", stable); end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || result !== 32'd99) begin fails++; $display("FAIL bp_replace: got valid=%b result=%h want 1 00000063", out_valid, result); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_mul;
      int seen;
      @(negedge clk);
      drive(32'd3, 32'd5, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmm_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rmm_reset: got valid=%b result=%h busy=%b want 0 00000000 0", out_valid, result, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmm_in_ready: got %b want 1", in_ready); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL rmm_stale: got %0d cycles with activity want 0", seen); end
   endtask

   task automatic test_xlen8;
      logic [7:0] xa[3], xb[3], xe[3];
      logic [2:0] xf3[3];
      logic       xf7[3];
      xa  = '{8'h7F, 8'h80, 8'h7F};
      xb  = '{8'h01, 8'h0C, 8'h01};
      xf3 = '{3'b000, 3'b101, 3'b011};
      xf7 = '{1'b0, 1'b1, 1'b0};
      xe  = '{8'h80, 8'hF8, 8'h00};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         v8 = 1'b1; a8 = xa[i]; b8 = xb[i]; f3_8 = xf3[i]; f7_8 = xf7[i]; m8 = 1'b1;
         @(negedge clk);
         v8 = 1'b0;
         tests++;
         if (ov8 !== 1'b1 || busy8 !== 1'b0 || res8 !== xe[i]) begin
            fails++;
            $display("FAIL xlen8[%0d]: got valid=%b busy=%b result=%h want 1 0 %h", i, ov8, busy8, res8, xe[i]);
         end
      end
   endtask

   initial begin
      in_valid = 1'b0; operand_a = '0; operand_b = '0; funct3 = 3'b000;
      funct7 = 1'b0; mul_en = 1'b0; out_ready = 1'b1;
      v8 = 1'b0; a8 = '0; b8 = '0; f3_8 = 3'b000; f7_8 = 1'b0; m8 = 1'b0; ordy8 = 1'b1;
      test_reset();
      test_base_ops();
      test_mul();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_mul();
      test_xlen8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the single-cycle RV32 ALU.
- Implements the full RV32I register-register ALU op set at width XLEN, plus optional iterative MUL/MULHU (shift-add, one bit per cycle).
- Sits between decode/operand-fetch and writeback, with valid/ready handshakes on both sides so that multi-cycle ops can stall issue.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 8..64, power of two.
- MUL_EN, 1, 1 = multiply unit present; 0 = mul_en input ignored and ops decode as base ALU.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept request this cycle
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- funct3  in  3  RISC-V funct3
- funct7  in  1  instr[30]: SUB/SRA select
- mul_en  in  1  instr[25]: M-extension select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, rst=1): state=S_IDLE; out_valid=0, result=0, busy=0; in_ready=1 one cycle after rst deasserts. A multiply in flight when rst asserts is discarded and its result is never presented.
- States: S_IDLE (empty), S_MUL (iterating), S_OUT (result held).
- Handshake:
  - Accept on in_valid&&in_ready.
  - Deliver on out_valid&&out_ready.
  - in_ready = (state==S_IDLE) || (state==S_OUT && out_ready).
  - out_valid = (state==S_OUT).
- Stability: result and out_valid stay stable while out_valid=1 and out_ready=0.
- Base ops (mul_en=0 or MUL_EN=0), result registered, latency 1: accept in cycle N -> out_valid in N+1.
  - 000: funct7 ? A-B : A+B (mod 2^XLEN).
  - 001: A << B[SHW-1:0].
  - 010: signed(A) < signed(B) ? 1 : 0.
  - 011: unsigned compare, same encoding.
  - 100: A^B.
  - 101: funct7 ? arithmetic >> : logical >>, amount B[SHW-1:0].
  - 110: A|B.
  - 111: A&B.
  - Upper bits of B beyond SHW are ignored for shifts.
- Back-to-back: with out_ready held 1, one base op per cycle (S_OUT -> S_OUT).
- Multiply (mul_en=1, MUL_EN=1):
  - funct3 000 = MUL: low XLEN bits of A*B.
  - funct3 011 = MULHU: high XLEN bits of the unsigned product.
  - Any other funct3 with mul_en=1: result=0, latency 1, no S_MUL.
  - On accept: latch A, B, op; clear 2*XLEN accumulator and counter; go to S_MUL; busy=1.
  - Each S_MUL cycle: if multiplier LSB is 1, add the shifted multiplicand to the accumulator; shift multiplier right and multiplicand left; counter++.
  - After XLEN iterations: go to S_OUT; busy=0; result = selected half.
  - Latency: accept in N -> out_valid in N+XLEN+1. in_ready=0 throughout S_MUL.
- Transitions:
  - S_IDLE -> S_OUT on accepting a base op; S_IDLE -> S_MUL on accepting a mul.
  - S_OUT with out_ready: -> S_IDLE if no new accept, else -> S_OUT or S_MUL per the new op.
  - S_OUT without out_ready: hold.
- Simultaneous events: a delivery and a new accept in the same cycle are legal; the new result replaces the old one in the next cycle.
- Edge values: A=0 or B=0 still takes full mul latency. The product of two all-ones operands must not overflow the accumulator.

Test Plan:
- Reset/idle: assert rst mid-MUL (cycle 5) -> out_valid=0, result=0 immediately; in_ready=1 after release; no stale result ever appears.
- Arithmetic edges (XLEN=32):
  - ADD 0xFFFFFFFF+1 -> 0x00000000 at N+1.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0x80000000,1 -> 1; SLTU same operands -> 0.
- Shifts:
  - SRA 0x80000000 by B=0x00000024 (amount 4) -> 0xF8000000.
  - SRL same -> 0x08000000.
  - SLL 1 by 31 -> 0x80000000.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE; out_valid exactly at N+33; busy=1 for 32 cycles; in_ready=0 meanwhile.
- Backpressure/throughput:
  - 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
  - out_ready=0 for 3 cycles -> result held stable, in_ready=0; release -> next op accepted same cycle.
- Parameter sweep: XLEN=8, MUL_EN=0; mul_en=1 with funct3=000, A=0x7F, B=0x01 -> ADD result 0x80 at N+1, no S_MUL.
